// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a 4:1 datapath mux: one-hot grants,
// mux select, registered data capture and a per-tenure hold limit.
module mux_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANT   = 1'b1;
    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    // Returns {found, index}: first set bit of r scanning p, p+1, ... mod 4.
    function automatic logic [2:0] pick_f(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot_f(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] in_sel_s;
    logic [3:0]       req_mask_s;
    logic [2:0]       pick_s;
    logic             hit_s;

    // Data of the currently selected requester.
    always_comb begin
        in_sel_s = '0;
        case (sel_q)
            2'd0:    in_sel_s = in0;
            2'd1:    in_sel_s = in1;
            2'd2:    in_sel_s = in2;
            2'd3:    in_sel_s = in3;
            default: in_sel_s = '0;
        endcase
    end

    // The holder is never a candidate for its own successor pick.
    always_comb begin
        req_mask_s = req;
        if (state_q == ST_GRANT) begin
            req_mask_s = req & ~onehot_f(sel_q);
        end else begin
            req_mask_s = req;
        end
        pick_s = pick_f(req_mask_s, ptr_q);
        hit_s  = req[sel_q];
    end

    // Next-state logic for grant sequencing and capture.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    gnt_d   = onehot_f(pick_s[1:0]);
                    sel_d   = pick_s[1:0];
                    cnt_d   = 4'd1;
                    ptr_d   = pick_s[1:0] + 2'd1;
                    state_d = ST_GRANT;
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (hit_s) begin
                    out_data_d  = in_sel_s;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
                if (!hit_s || (cnt_q == MAX_HOLD_C)) begin
                    if (pick_s[2]) begin
                        gnt_d = onehot_f(pick_s[1:0]);
                        sel_d = pick_s[1:0];
                        cnt_d = 4'd1;
                        ptr_d = pick_s[1:0] + 2'd1;
                    end else if (hit_s) begin
                        // Limit reached with nobody else waiting: same holder again.
                        cnt_d = 4'd1;
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= 4'd0;
            gnt_q       <= 4'b0000;
            sel_q       <= 2'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: two instances (hold limits 4 and 2),
// directed request patterns, captured words checked by per-instance monitors.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       resetn;
    logic [3:0] req4, req2;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] gnt4, gnt2;
    logic [1:0] sel4, sel2;
    logic [7:0] od4, od2;
    logic       ov4, ov2, busy4, busy2;

    int checks = 0;
    int errors = 0;
    logic [7:0] q4[$];
    logic [7:0] q2[$];
    logic [7:0] e4, e2;
    logic [7:0] vals [4];
    logic [3:0] exp_g;

    mux_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .req(req4),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .gnt(gnt4), .sel(sel4), .out_data(od4), .out_valid(ov4), .busy(busy4)
    );

    mux_rr_arbiter #(.WIDTH(8), .MAX_HOLD(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .req(req2),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .gnt(gnt2), .sel(sel2), .out_data(od2), .out_valid(ov2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor for the MAX_HOLD=4 instance.
    always @(negedge clk) begin
        if (ov4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL out4_unexpected: got out_valid=1 data=%0h expected no capture", od4);
            end else begin
                e4 = q4.pop_front();
                if (od4 !== e4) begin
                    errors++;
                    $display("FAIL out4_data: got %0h expected %0h", od4, e4);
                end
            end
        end
    end

    // Monitor for the MAX_HOLD=2 instance.
    always @(negedge clk) begin
        if (ov2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL out2_unexpected: got out_valid=1 data=%0h expected no capture", od2);
            end else begin
                e2 = q2.pop_front();
                if (od2 !== e2) begin
                    errors++;
                    $display("FAIL out2_data: got %0h expected %0h", od2, e2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1;
        req4 = 4'b0000;
        req2 = 4'b0000;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt4",  32'(gnt4),  32'h0);
        chk("rst_sel4",  32'(sel4),  32'h0);
        chk("rst_data4", 32'(od4),   32'h0);
        chk("rst_ov4",   32'(ov4),   32'h0);
        chk("rst_busy4", 32'(busy4), 32'h0);
        chk("rst_gnt2",  32'(gnt2),  32'h0);
        resetn = 1'b1;
        cyc();
        chk("idle_gnt4", 32'(gnt4), 32'h0);

        // Single requester 2 with hold limit 4: continuous captures across re-grant.
        in2  = 8'hA5;
        req4 = 4'b0100;
        cyc();
        chk("a_gnt",  32'(gnt4),  32'h4);
        chk("a_sel",  32'(sel4),  32'h2);
        chk("a_ov0",  32'(ov4),   32'h0);
        chk("a_busy", 32'(busy4), 32'h1);
        for (int i = 0; i < 6; i++) begin
            q4.push_back(8'hA5);
            cyc();
            chk("a_gnt_hold", 32'(gnt4), 32'h4);
        end

        // Idle return: only requester drops.
        req4 = 4'b0000;
        in2  = 8'h5A;
        cyc();
        chk("idle_gnt",  32'(gnt4),  32'h0);
        chk("idle_busy", 32'(busy4), 32'h0);
        chk("idle_sel",  32'(sel4),  32'h2);
        chk("idle_ov",   32'(ov4),   32'h0);
        chk("idle_data", 32'(od4),   32'hA5);
        cyc();
        chk("idle_ov2", 32'(ov4), 32'h0);

        // Pointer is 3 after requester 2's tenure: scan 3,0 picks 0.
        in0 = 8'h11; in1 = 8'h22; in3 = 8'h33;
        req4 = 4'b0011;
        cyc();
        chk("ptr_gnt", 32'(gnt4), 32'h1);
        chk("ptr_sel", 32'(sel4), 32'h0);
        q4.push_back(8'h11);
        cyc();
        req4 = 4'b1010;
        cyc();
        chk("drop0_gnt", 32'(gnt4), 32'h2);
        chk("drop0_sel", 32'(sel4), 32'h1);
        chk("drop0_ov",  32'(ov4),  32'h0);
        q4.push_back(8'h22);
        cyc();
        // Early drop of requester 1 hands over to 3 on the same edge.
        req4 = 4'b1000;
        cyc();
        chk("drop1_gnt", 32'(gnt4), 32'h8);
        chk("drop1_sel", 32'(sel4), 32'h3);
        chk("drop1_ov",  32'(ov4),  32'h0);
        q4.push_back(8'h33);
        cyc();
        req4 = 4'b0000;
        cyc();
        chk("end4_gnt",  32'(gnt4),  32'h0);
        chk("end4_busy", 32'(busy4), 32'h0);

        // Rotation with hold limit 2: 0,1,2,3,0 with two captures each.
        vals[0] = 8'h10; vals[1] = 8'h21; vals[2] = 8'hA5; vals[3] = 8'h3C;
        in0 = vals[0]; in1 = vals[1]; in2 = vals[2]; in3 = vals[3];
        req2 = 4'b1111;
        cyc();
        chk("rot_gnt0", 32'(gnt2), 32'h1);
        chk("rot_sel0", 32'(sel2), 32'h0);
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 2; c++) begin
                q2.push_back(vals[t % 4]);
                cyc();
                exp_g = 4'b0001 << ((c == 0) ? (t % 4) : ((t + 1) % 4));
                chk("rot_gnt", 32'(gnt2), 32'(exp_g));
                chk("rot_sel", 32'(sel2), (c == 0) ? 32'(t % 4) : 32'((t + 1) % 4));
            end
        end

        // Reset asserted mid-tenure clears outputs immediately.
        req2 = 4'b0011;
        q2.push_back(vals[1]);
        cyc();
        chk("mid_gnt", 32'(gnt2), 32'h2);
        #2 resetn = 1'b0;
        #1;
        chk("mrst_gnt",  32'(gnt2),  32'h0);
        chk("mrst_sel",  32'(sel2),  32'h0);
        chk("mrst_ov",   32'(ov2),   32'h0);
        chk("mrst_data", 32'(od2),   32'h0);
        chk("mrst_busy", 32'(busy2), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        cyc();
        chk("post_gnt", 32'(gnt2), 32'h1);
        chk("post_sel", 32'(sel2), 32'h0);
        q2.push_back(vals[0]);
        cyc();
        req2 = 4'b0000;
        cyc();
        chk("end2_gnt", 32'(gnt2), 32'h0);
        chk("end2_ov",  32'(ov2),  32'h0);
        cyc();
        chk("q4_drained", 32'(q4.size()), 32'h0);
        chk("q2_drained", 32'(q2.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
